// File: rtl/pipe_pkg.sv
// Shared fetch-stage types: reset/vector defaults, fetch FSM states,
// redirect causes and a word-alignment helper.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0180;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_EXC    = 3'd1,
        C_IRQ    = 3'd2,
        C_JR     = 3'd3,
        C_JUMP   = 3'd4,
        C_BRANCH = 3'd5
    } redir_cause_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: exception, interrupt, jr, jump, branch.
// Produces the redirect flag, its cause and a word-aligned target.
module next_pc_sel
    import pipe_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic         i_exc,
    input  logic         i_irq,
    input  logic         i_irq_en,
    input  logic         i_jr,
    input  logic [31:0]  i_jr_target,
    input  logic         i_jump,
    input  logic [31:0]  i_jump_target,
    input  logic         i_branch_taken,
    input  logic [31:0]  i_branch_target,
    output logic         o_redir,
    output redir_cause_t o_cause,
    output logic [31:0]  o_target
);

    logic w_irq;

    assign w_irq = i_irq & i_irq_en;

    always_comb begin
        o_cause  = C_NONE;
        o_target = '0;
        priority case (1'b1)
            i_exc: begin
                o_cause  = C_EXC;
                o_target = align_word(EXC_VEC);
            end
            w_irq: begin
                o_cause  = C_IRQ;
                o_target = align_word(EXC_VEC);
            end
            i_jr: begin
                o_cause  = C_JR;
                o_target = align_word(i_jr_target);
            end
            i_jump: begin
                o_cause  = C_JUMP;
                o_target = align_word(i_jump_target);
            end
            i_branch_taken: begin
                o_cause  = C_BRANCH;
                o_target = align_word(i_branch_target);
            end
            default: ;
        endcase
    end

    assign o_redir = (o_cause != C_NONE);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ready
// handshake and feeds PC/IFInst/PC_IFWrite/IF_Flush to the IF/ID register.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic [31:0] epc_in,
    input  logic        irq,
    input  logic        irq_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IFInst,
    output logic        PC_IFWrite,
    output logic        IF_Flush,
    output logic [31:0] EPC
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_inst_buf;
    logic [31:0]  r_epc;
    logic [31:0]  r_drop_addr;

    logic         w_redir;
    redir_cause_t w_cause;
    logic [31:0]  w_target;
    logic         w_fetch_valid;

    next_pc_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_next_pc_sel (
        .i_exc           (exc),
        .i_irq           (irq),
        .i_irq_en        (irq_en),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_redir         (w_redir),
        .o_cause         (w_cause),
        .o_target        (w_target)
    );

    assign w_fetch_valid = ((r_state == S_FETCH) & imem_ready)
                         | (r_state == S_HOLD);

    // Request drops with reset itself so an aborted fetch never lingers.
    assign imem_req   = reset & (r_state != S_HOLD);
    assign imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign IFInst     = (r_state == S_HOLD) ? r_inst_buf : imem_rdata;
    assign PC_IFWrite = PC_Write & w_fetch_valid & ~w_redir;
    assign IF_Flush   = w_redir;
    assign PC         = r_pc;
    assign EPC        = r_epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= align_word(RESET_PC);
            r_inst_buf  <= '0;
            r_epc       <= '0;
            r_drop_addr <= '0;
        end else begin
            if (w_cause == C_EXC) begin
                r_epc <= epc_in;
            end else if (w_cause == C_IRQ) begin
                r_epc <= r_pc;
            end

            if (w_redir) begin
                r_pc <= w_target;
                // An unanswered request must stay on the bus; park it.
                unique case (r_state)
                    S_FETCH: begin
                        if (!imem_ready) begin
                            r_drop_addr <= r_pc;
                            r_state     <= S_DROP;
                        end
                    end
                    S_HOLD:  r_state <= S_FETCH;
                    S_DROP:  r_state <= S_DROP;
                    default: r_state <= S_FETCH;
                endcase
            end else begin
                unique case (r_state)
                    S_FETCH: begin
                        if (imem_ready) begin
                            if (PC_Write) begin
                                r_pc <= r_pc + 32'd4;
                            end else begin
                                r_inst_buf <= imem_rdata;
                                r_state    <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (PC_Write) begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= S_FETCH;
                        end
                    end
                    S_DROP: begin
                        if (imem_ready) begin
                            r_state <= S_FETCH;
                        end
                    end
                    default: r_state <= S_FETCH;
                endcase
            end
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and selects the next PC: sequential, branch, jump, jump-register, or exception/interrupt vector.
- Drives a request/ready instruction-memory handshake that tolerates variable memory latency.
- Produces PC, IFInst, PC_IFWrite and IF_Flush for the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
EXC_VEC, 32'h8000_0180, target on exception or interrupt

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PC_Write  in  1  hazard unit: 1 = fetch may advance, 0 = load-use stall
branch_taken  in  1  ID-stage branch resolved taken
branch_target  in  32  branch target
jump  in  1  J/JAL in ID
jump_target  in  32  jump target
jr  in  1  JR/JALR in ID
jr_target  in  32  register target
exc  in  1  synchronous exception from a later stage
epc_in  in  32  PC of the faulting instruction
irq  in  1  external interrupt, level
irq_en  in  1  interrupt enable
imem_req  out  1  instruction request
imem_addr  out  32  request address, word aligned
imem_ready  in  1  response valid this cycle
imem_rdata  in  32  instruction word
PC  out  32  PC of the instruction presented on IFInst
IFInst  out  32  fetched instruction
PC_IFWrite  out  1  IF/ID load enable
IF_Flush  out  1  IF/ID flush on redirect
EPC  out  32  exception return address

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, state=S_FETCH, inst_buf=0, EPC=0, drop_addr=0.
  - imem_req forced to 0 while reset is low.
  - First request issues in the first cycle after release.
- redir = exc | (irq & irq_en) | jr | jump | branch_taken.
- Target priority: exc, irq, jr, jump, branch. Low 2 bits of every target are forced to 0.
- IF_Flush = redir (combinational).
- States:
  - S_FETCH: imem_req=1, imem_addr=PC.
  - S_HOLD: imem_req=0. Instruction is buffered and waiting for PC_Write.
  - S_DROP: imem_req=1, imem_addr=drop_addr. A stale request is outstanding; its data is discarded.
- fetch_valid = (S_FETCH & imem_ready) | S_HOLD.
- IFInst = S_HOLD ? inst_buf : imem_rdata.
- PC_IFWrite = PC_Write & fetch_valid & ~redir.
- Transitions when redir=0:
  - S_FETCH, ready, PC_Write: PC<=PC+4 (wraps mod 2^32), stay S_FETCH. Zero-wait memory gives 1 instruction per cycle.
  - S_FETCH, ready, ~PC_Write: inst_buf<=imem_rdata, go S_HOLD.
  - S_FETCH, ~ready: hold PC, keep the request stable.
  - S_HOLD, PC_Write: PC<=PC+4, go S_FETCH.
  - S_DROP, ready: go S_FETCH.
- Transitions when redir=1 (wins over PC_Write and over stall):
  - PC<=target in every state.
  - S_FETCH & ~ready: drop_addr<=PC, go S_DROP. The request must stay asserted with its address unchanged until ready.
  - S_FETCH & ready: discard data, stay S_FETCH.
  - S_HOLD: discard inst_buf, go S_FETCH.
  - S_DROP: stay S_DROP with the newest target.
- EPC:
  - EPC<=epc_in on exc.
  - EPC<=PC on an irq redirect when exc=0.
  - Otherwise EPC holds.
- Reset low mid-request: the FSM aborts immediately. The memory must tolerate a dropped request.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC and EXC_VEC defaults.
  - fetch state enum (S_FETCH, S_HOLD, S_DROP).
  - redirect-cause encoding.
- Sub-module next_pc_sel: combinational priority mux producing redir and the aligned target.

Test Plan:
- Zero-wait memory (imem_ready=1), PC_Write=1 after reset -> imem_addr 0,4,8,C on successive cycles; PC_IFWrite=1 each cycle; IF_Flush=0.
- PC_Write=0 for 2 cycles at PC=8, ready=1 -> S_HOLD; IFInst holds the word at 8; imem_req=0; PC_IFWrite=0; on resume PC becomes C.
- imem_ready delayed 3 cycles -> imem_addr stable and imem_req=1 throughout; PC_IFWrite pulses exactly once when ready rises.
- branch_taken, target 0x40, while a request to 0x10 is pending -> IF_Flush=1; addr stays 0x10 until ready; that data is discarded; next request is 0x40.
- jr=1 (target 0x103) and jump=1 in the same cycle -> PC=0x100; exc + branch together -> PC=EXC_VEC, EPC=epc_in.
- reset driven low during S_DROP -> state S_FETCH, PC=RESET_PC, imem_req=0 immediately; after release the first address is RESET_PC.
